// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a single-port byte memory.
// Wide (16-bit little-endian) accesses are split into two byte cycles; responses are registered.
module mem_access_unit #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic           req_wide,
    input  logic [A-1:0]   req_addr,
    input  logic [2*W-1:0] req_wdata,
    output logic           resp_valid,
    output logic [2*W-1:0] resp_rdata,
    output logic [A-1:0]   mem_addr,
    output logic [W-1:0]   mem_data_to_write,
    output logic           mem_read_enabled,
    output logic           mem_write_enabled,
    input  logic [W-1:0]   mem_data_out
);

    // state | meaning
    // IDLE  | ready for a request
    // BYTE0 | memory cycle on the low byte (addr)
    // BYTE1 | memory cycle on the high byte (addr+1, wrapping)
    // RESP  | one-cycle response pulse
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [2*W-1:0] wdata_q, wdata_d;
    logic           write_q, write_d;
    logic           wide_q, wide_d;
    logic [W-1:0]   rlo_q, rlo_d;
    logic [2*W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            rlo_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            rlo_q   <= rlo_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        write_d           = write_q;
        wide_d            = wide_q;
        rlo_d             = rlo_q;
        rdata_d           = rdata_q;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        mem_addr          = '0;
        mem_data_to_write = '0;
        mem_read_enabled  = 1'b0;
        mem_write_enabled = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    wide_d  = req_wide;
                    state_d = BYTE0;
                end
            end
            BYTE0: begin
                mem_addr = addr_q;
                if (write_q) begin
                    mem_write_enabled = 1'b1;
                    mem_data_to_write = wdata_q[W-1:0];
                end else begin
                    mem_read_enabled = 1'b1;
                    rlo_d = mem_data_out;
                    // A narrow load publishes its result on the edge into RESP.
                    if (!wide_q) rdata_d = {{W{1'b0}}, mem_data_out};
                end
                state_d = wide_q ? BYTE1 : RESP;
            end
            BYTE1: begin
                mem_addr = addr_q + {{(A-1){1'b0}}, 1'b1};
                if (write_q) begin
                    mem_write_enabled = 1'b1;
                    mem_data_to_write = wdata_q[2*W-1:W];
                end else begin
                    mem_read_enabled = 1'b1;
                    rdata_d = {mem_data_out, rlo_q};
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 256x8 memory attached.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_wide = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data_to_write;
    logic        mem_read_enabled;
    logic        mem_write_enabled;
    logic [7:0]  mem_data_out;

    mem_access_unit #(.W(8), .A(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_data_to_write(mem_data_to_write),
        .mem_read_enabled(mem_read_enabled), .mem_write_enabled(mem_write_enabled),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_write_enabled) mem[mem_addr] <= mem_data_to_write;

    typedef struct { logic [15:0] rdata; int cyc; } resp_t;
    resp_t       resp_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  ref_mem [256];
    logic [15:0] last_rdata = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check_val("en_excl", {31'd0, mem_read_enabled & mem_write_enabled}, 32'd0);
            if (!mem_read_enabled && !mem_write_enabled)
                check_val("idle_bus", {16'd0, mem_addr, mem_data_to_write}, 32'd0);
            if (mem_write_enabled) begin
                if (wr_q.size() == 0) check_val("wr_unexp", 32'd1, 32'd0);
                else check_val("wr_bus", {16'd0, mem_addr, mem_data_to_write}, {16'd0, wr_q.pop_front()});
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) check_val("resp_unexp", 32'd1, 32'd0);
                else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check_val("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
                    check_val("resp_lat", cyc, e.cyc);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit wr, input bit wide, input logic [7:0] a,
                         input logic [15:0] wd, input bit hold);
        int g;
        int acc;
        logic [7:0] a1;
        resp_t e;
        a1 = a + 8'd1;
        req_write = wr; req_wide = wide; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) check_val("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        acc = cyc;
        if (wr) begin
            wr_q.push_back({a, wd[7:0]});
            ref_mem[a] = wd[7:0];
            if (wide) begin
                wr_q.push_back({a1, wd[15:8]});
                ref_mem[a1] = wd[15:8];
            end
        end else begin
            last_rdata = wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        e.rdata = last_rdata;
        e.cyc   = acc + (wide ? 2 : 1);
        resp_q.push_back(e);
        req_addr  = 8'($urandom);
        req_wdata = 16'($urandom);
        req_write = 1'($urandom);
        req_wide  = 1'($urandom);
        req_valid = hold;
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0) && g < 50) begin @(negedge clk); g++; end
        check_val("drain", resp_q.size() + wr_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_resp", {15'd0, resp_valid, resp_rdata}, 32'd0);
        check_val("rst_bus", {14'd0, mem_read_enabled, mem_write_enabled, mem_addr, mem_data_to_write}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(1, 0, 8'h10, 16'h00A5, 0);
        issue(0, 0, 8'h10, 16'h0000, 0);
        drain();

        issue(1, 1, 8'hFF, 16'hBEEF, 0);
        issue(0, 1, 8'hFF, 16'h0000, 0);
        drain();

        issue(1, 1, 8'h01, 16'h2211, 0);
        issue(1, 0, 8'h03, 16'h0033, 0);
        drain();
        issue(0, 0, 8'h01, 16'h0000, 1);
        issue(0, 0, 8'h02, 16'h0000, 1);
        issue(0, 0, 8'h03, 16'h0000, 0);
        drain();

        issue(1, 1, 8'h20, 16'h1234, 0);
        issue(0, 1, 8'h20, 16'h0000, 0);
        issue(1, 0, 8'h30, 16'h0055, 0);
        drain();
        check_val("hold_rdata", {16'd0, resp_rdata}, 32'h1234);

        issue(1, 0, 8'h41, 16'h0077, 0);
        drain();
        issue(1, 1, 8'h40, 16'h2211, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("arst_bus", {14'd0, mem_read_enabled, mem_write_enabled, mem_addr, mem_data_to_write}, 32'd0);
        check_val("arst_resp", {14'd0, req_ready, resp_valid, resp_rdata}, 32'h0002_0000);
        void'(wr_q.pop_back());
        void'(resp_q.pop_back());
        ref_mem[8'h41] = 8'h77;
        last_rdata = '0;
        @(negedge clk);
        check_val("arst_byte0", {24'd0, mem[8'h40]}, 32'h11);
        check_val("arst_byte1", {24'd0, mem[8'h41]}, 32'h77);
        reset = 1'b1;
        @(negedge clk);
        issue(0, 1, 8'h40, 16'h0000, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
